cic_decim_mc: RTL
=================

// Module: cic_decim_mc
// PURPOSE
//  Parametrised multichannel CIC decimator for the PDM microphone array.
//  Takes NUM_CH 1-bit PDM streams sampled together, runs ORDER integrators per channel at input rate.
//  Every DECIM accepted samples it snapshots the integrators and runs a time-multiplexed comb section.
//  Emits one Avalon-ST packet per frame: NUM_CH beats, channel-tagged, honouring backpressure and reporting overrun.
// PARAMETERS
//  NUM_CH  9   channel count, 1..16
//  ORDER   4   CIC stages, 1..6
//  DECIM   32  decimation ratio, power of two, 2..256, must be >= NUM_CH
//  OUT_W   19  output sample width (signed)
//  CH_W    4   out_channel width, >= clog2(NUM_CH)
//  ACC_W   derived localparam = ORDER*log2(DECIM)+2; must be >= OUT_W
// PORTS
//  clk                input   1       sole clock
//  reset_n            input   1       asynchronous active-low reset
//  in_valid           input   1       in_data holds one PDM bit per channel
//  in_ready           output  1       1 whenever out of reset (never stalls input)
//  in_data            input   NUM_CH  bit c = PDM sample of channel c
//  in_error           input   2       upstream error flags for this sample
//  out_valid          output  1       beat valid
//  out_ready          input   1       sink ready
//  out_data           output  OUT_W   decimated signed sample
//  out_channel        output  CH_W    channel index of beat
//  out_startofpacket  output  1       1 on channel 0 beat
//  out_endofpacket    output  1       1 on channel NUM_CH-1 beat
//  out_error          output  2       [1]=overrun before this frame, [0]=in_error seen in frame window
// BEHAVIOUR
//  Reset: all integrators, comb delays, snapshot bank, counters 0; in_ready, out_valid, sop, eop = 0;
//   out_data, out_channel, out_error = 0. in_ready rises on first clk edge after reset_n deasserts.
//  Input map: bit 1 -> +1, bit 0 -> -1, sign-extended to ACC_W. Integrators wrap modulo 2^ACC_W (intended).
//  Integrators advance only on in_valid&in_ready; phase counter 0..DECIM-1 advances on same.
//  Window error: err_acc |= |in_error per accepted sample; cleared at snapshot.
//  Snapshot: on accept with phase==DECIM-1, last-stage integrator values (incl. this sample) copied to snap[c].
//  FSM IDLE/EMIT, channel counter ch:
//   IDLE: snapshot pending -> EMIT, ch=0, out_valid=1 on next cycle (1-cycle latency from snapshot edge).
//   EMIT: out_data = comb chain of snap[ch] through ORDER cascaded differences with per-channel delay regs,
//    arithmetic shift right by ACC_W-OUT_W (truncation toward -inf), then take OUT_W LSBs.
//   Comb delay regs for ch update only when out_valid&out_ready; on stall all outputs hold stable.
//   Accepted beat with ch==NUM_CH-1 -> IDLE (or EMIT ch=0 if a new snapshot is pending).
//  sop = (ch==0)&out_valid, eop = (ch==NUM_CH-1)&out_valid. out_error constant across a frame.
//  Overrun: snapshot event while previous frame still in EMIT -> new frame dropped, integrators keep running,
//   overrun flag set; reported as out_error[1]=1 on every beat of the next emitted frame, then cleared.
//  Simultaneous final-beat accept and snapshot: no overrun; new frame starts next cycle.
//  Comb delays for dropped frames are not updated (first frame after overrun carries a transient; flagged).
//  Reset mid-frame: immediate abort, out_valid drops asynchronously, no partial packet resumes.
// TESTING
//  1. All-ones in_data, out_ready=1, defaults: frames 5.. output +131072 (2^20>>3) on all 9 channels.
//  2. All-zeros: settles to -131072; alternating 1/0 per sample: settles to 0; channels independent (mix per bit).
//  3. Packet framing: ch 0..8 in order, sop only ch0, eop only ch8, exactly 9 beats per 32 accepted inputs.
//  4. Backpressure: out_ready toggled randomly at 50%: data/channel stable under stall, values match model.
//  5. Overrun: hold out_ready=0 for 40 cycles across a snapshot -> that frame dropped, next frame out_error[1]=1.
//  6. in_error=2'b01 on one sample of window k -> frame k all beats out_error[0]=1, frame k+1 clear;
//     reset_n pulsed mid-EMIT -> out_valid=0 at once, all outputs 0, restart matches fresh-run model.

Source files
------------

// File: rtl/cic_decim_mc.sv
// Multichannel CIC decimator for a PDM microphone array.
// Per-channel integrators run at the input rate. Every DECIM accepted samples
// the last integrator stage of each channel is captured into a snapshot bank.
// A single comb section is shared across channels and walks that bank, one
// channel per output beat. Each frame leaves as one Avalon-ST packet.
//
//  state | meaning
//  ------+---------------------------------------------------------------
//  IDLE  | no frame in flight, waiting for the next snapshot
//  EMIT  | presenting snap[ch] through the comb chain, one beat per channel
module cic_decim_mc #(
    parameter int NUM_CH = 9,
    parameter int ORDER  = 4,
    parameter int DECIM  = 32,
    parameter int OUT_W  = 19,
    parameter int CH_W   = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [NUM_CH-1:0] in_data,
    input  logic [1:0]        in_error,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  out_data,
    output logic [CH_W-1:0]   out_channel,
    output logic              out_startofpacket,
    output logic              out_endofpacket,
    output logic [1:0]        out_error
);
    localparam int LOG_D = $clog2(DECIM);
    localparam int ACC_W = ORDER * LOG_D + 2;
    localparam logic [LOG_D-1:0] PH_LAST = LOG_D'(DECIM - 1);
    localparam logic [CH_W-1:0]  CH_LAST = CH_W'(NUM_CH - 1);

    typedef enum logic {IDLE, EMIT} state_t;

    state_t            state_q, state_d;
    logic [CH_W-1:0]   ch_q, ch_d;
    logic [LOG_D-1:0]  phase;
    logic              err_acc;
    logic              overrun;
    logic              frame_err;
    logic              frame_ovr;

    logic [ACC_W-1:0]  integ     [NUM_CH][ORDER];
    logic [ACC_W-1:0]  integ_nxt [NUM_CH][ORDER];
    logic [ACC_W-1:0]  snap      [NUM_CH];
    logic [ACC_W-1:0]  comb_dly  [NUM_CH][ORDER];
    logic [ACC_W-1:0]  stage_in  [ORDER+1];

    logic accept, snap_evt, beat_acc, last_acc, frame_load, ovr_evt;

    assign accept   = in_valid & in_ready;
    assign snap_evt = accept & (phase == PH_LAST);

    // Integrator cascade: a PDM bit maps to +1/-1, each stage adds the freshly updated stage before it.
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            integ_nxt[c][0] = integ[c][0] + (in_data[c] ? ACC_W'(1) : {ACC_W{1'b1}});
            for (int k = 1; k < ORDER; k++) begin
                integ_nxt[c][k] = integ[c][k] + integ_nxt[c][k-1];
            end
        end
    end

    // Shared comb chain evaluated for the channel currently being emitted.
    always_comb begin
        stage_in[0] = snap[ch_q];
        for (int k = 0; k < ORDER; k++) begin
            stage_in[k+1] = stage_in[k] - comb_dly[ch_q][k];
        end
    end

    // Next-state logic; a snapshot is dropped (overrun) unless the frame path is free this cycle.
    always_comb begin
        state_d    = state_q;
        ch_d       = ch_q;
        beat_acc   = (state_q == EMIT) & out_ready;
        last_acc   = beat_acc & (ch_q == CH_LAST);
        frame_load = snap_evt & ((state_q == IDLE) | last_acc);
        ovr_evt    = snap_evt & ~frame_load;
        case (state_q)
            IDLE: begin
                if (snap_evt) begin
                    state_d = EMIT;
                    ch_d    = '0;
                end
            end
            EMIT: begin
                if (last_acc) begin
                    state_d = snap_evt ? EMIT : IDLE;
                    ch_d    = '0;
                end else if (beat_acc) begin
                    ch_d = ch_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                ch_d    = '0;
            end
        endcase
    end

    // FSM state and channel counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            ch_q    <= '0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
        end
    end

    // Input side: ready, phase counter, window error and integrators.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            in_ready <= 1'b0;
            phase    <= '0;
            err_acc  <= 1'b0;
            for (int c = 0; c < NUM_CH; c++) begin
                for (int k = 0; k < ORDER; k++) begin
                    integ[c][k] <= '0;
                end
            end
        end else begin
            in_ready <= 1'b1;
            if (accept) begin
                phase   <= phase + 1'b1;
                err_acc <= snap_evt ? 1'b0 : (err_acc | (|in_error));
                integ   <= integ_nxt;
            end
        end
    end

    // Snapshot bank and per-frame status; overrun is carried into the next frame that gets loaded.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overrun   <= 1'b0;
            frame_err <= 1'b0;
            frame_ovr <= 1'b0;
            for (int c = 0; c < NUM_CH; c++) begin
                snap[c] <= '0;
            end
        end else if (frame_load) begin
            overrun   <= 1'b0;
            frame_err <= err_acc | (|in_error);
            frame_ovr <= overrun;
            for (int c = 0; c < NUM_CH; c++) begin
                snap[c] <= integ_nxt[c][ORDER-1];
            end
        end else if (ovr_evt) begin
            overrun <= 1'b1;
        end
    end

    // Comb delay registers of the current channel advance only on an accepted beat.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int c = 0; c < NUM_CH; c++) begin
                for (int k = 0; k < ORDER; k++) begin
                    comb_dly[c][k] <= '0;
                end
            end
        end else if (beat_acc) begin
            for (int k = 0; k < ORDER; k++) begin
                comb_dly[ch_q][k] <= stage_in[k];
            end
        end
    end

    // Output beat: arithmetic shift right keeps the top OUT_W bits of the comb result.
    always_comb begin
        out_valid         = (state_q == EMIT);
        out_data          = out_valid ? stage_in[ORDER][ACC_W-1 -: OUT_W] : '0;
        out_channel       = out_valid ? ch_q : '0;
        out_startofpacket = out_valid & (ch_q == '0);
        out_endofpacket   = out_valid & (ch_q == CH_LAST);
        out_error         = out_valid ? {frame_ovr, frame_err} : 2'b00;
    end

endmodule
